// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch into a DEPTH-entry queue, throttled by request credits.
// Define FETCH_STATS_EN to add the stat_fetched / stat_redirects counters.
module fetch_queue #(
  parameter int unsigned   AW       = 64,
  parameter int unsigned   IW       = 32,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rsp_valid,
  input  logic [IW-1:0] imem_rsp_data,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [IW-1:0] instr_data,
  output logic [AW-1:0] instr_pc,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]   stat_fetched,
  output logic [31:0]   stat_redirects
`endif
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_pc, r_rsp_pc;
  logic [CW-1:0] r_count, r_outstanding, r_drop_cnt;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [IW-1:0] r_q_data [DEPTH];
  logic [AW-1:0] r_q_pc   [DEPTH];

  logic          w_req_fire, w_rsp_take, w_push, w_pop;
  logic [CW:0]   w_credit;
  logic [CW-1:0] w_drop_nxt, w_drop_redir;
  logic [AW-1:0] w_redir_pc;
  logic          w_unused_lsb;

  assign w_redir_pc   = {redirect_pc[AW-1:2], 2'b00};
  assign w_unused_lsb = ^redirect_pc[1:0];

  assign w_credit     = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req_fire   = imem_req_valid && imem_req_ready;
  // Responses with nothing in flight (e.g. left over from before a reset) are ignored.
  assign w_rsp_take   = imem_rsp_valid && (r_outstanding != '0);
  assign w_push       = w_rsp_take && (r_state == FETCH) && !redirect_valid;
  assign w_pop        = instr_valid && instr_ready;
  // No request can fire in a redirect cycle, so only the arriving response reduces the count.
  assign w_drop_redir = r_outstanding - CW'(w_rsp_take);

  assign imem_addr    = r_pc;
  assign instr_valid  = (r_count != '0);
  assign instr_data   = r_q_data[r_rptr];
  assign instr_pc     = r_q_pc[r_rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= FETCH;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_drop_cnt <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_drop_nxt     = r_drop_cnt;
    imem_req_valid = 1'b0;
    if (redirect_valid) begin
      w_drop_nxt  = w_drop_redir;
      w_state_nxt = (w_drop_redir != '0) ? DRAIN : FETCH;
    end else begin
      case (r_state)
        FETCH: imem_req_valid = rst && (w_credit < (CW+1)'(DEPTH));
        DRAIN: begin
          if (w_rsp_take) begin
            w_drop_nxt = r_drop_cnt - CW'(1);
            if (r_drop_cnt == CW'(1)) w_state_nxt = FETCH;
          end
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  // Response address is tracked as a second PC: responses return in request order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_take);
      if (redirect_valid) begin
        r_pc     <= w_redir_pc;
        r_rsp_pc <= w_redir_pc;
        r_count  <= '0;
        r_wptr   <= '0;
        r_rptr   <= '0;
      end else begin
        if (w_req_fire) r_pc <= r_pc + AW'(4);
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + AW'(4);
          r_wptr   <= r_wptr + PW'(1);
        end
        if (w_pop) r_rptr <= r_rptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_data[r_wptr] <= imem_rsp_data;
      r_q_pc[r_wptr]   <= r_rsp_pc;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched   <= '0;
      stat_redirects <= '0;
    end else begin
      if (w_pop)          stat_fetched   <= stat_fetched + 32'd1;
      if (redirect_valid) stat_redirects <= stat_redirects + 32'd1;
    end
  end
`endif

endmodule
